// File: rtl/pipe_register.sv
// DEPTH-stage valid/ready pipeline register with clock enable and flush.
// Define PIPE_REGISTER_OCCUPANCY_EN to add the registered occupancy port.
module pipe_register #(
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    DEPTH       = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data
`ifdef PIPE_REGISTER_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]                 r_valid;
  logic [DEPTH-1:0][WORD_WIDTH-1:0] r_data;
  logic [DEPTH-1:0]                 w_adv;
  logic                             w_room;
  logic                             w_in_fire;

  // Walk from the output side: each stage learns whether the next one frees up.
  always_comb begin : adv_chain
    logic room;
    logic adv;
    w_adv = '0;
    room  = m_ready && clk_en;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv      = r_valid[k] && room;
      w_adv[k] = adv;
      room     = !r_valid[k] || adv;
    end
    w_room = room;
  end

  assign s_ready   = clk_en && !flush && w_room;
  assign w_in_fire = s_valid && s_ready;
  assign m_valid   = r_valid[DEPTH-1] && clk_en;
  assign m_data    = r_data[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= {DEPTH{RESET_VALUE}};
    end else if (clk_en) begin
      if (flush) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= w_in_fire || (r_valid[0] && !w_adv[0]);
        if (w_in_fire) r_data[0] <= s_data;
        for (int k = 1; k < DEPTH; k++) begin
          r_valid[k] <= w_adv[k-1] || (r_valid[k] && !w_adv[k]);
          if (w_adv[k-1]) r_data[k] <= r_data[k-1];
        end
      end
    end
  end

`ifdef PIPE_REGISTER_OCCUPANCY_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic          w_out_fire;
  logic [OW-1:0] r_occ;

  assign w_out_fire = w_adv[DEPTH-1];
  assign occupancy  = r_occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= '0;
    end else if (clk_en) begin
      if (flush)
        r_occ <= '0;
      else if (w_in_fire && !w_out_fire)
        r_occ <= r_occ + OW'(1);
      else if (!w_in_fire && w_out_fire)
        r_occ <= r_occ - OW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register: directed DEPTH=2 sequences and a
// randomised DEPTH=1 run; occupancy checks follow PIPE_REGISTER_OCCUPANCY_EN.
module tb_pipe_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DEPTH=2 instance
  logic       a_reset, a_clk_en, a_flush, a_s_valid, a_m_ready;
  logic       a_s_ready, a_m_valid;
  logic [7:0] a_s_data, a_m_data;
`ifdef PIPE_REGISTER_OCCUPANCY_EN
  logic [1:0] a_occ;
`endif

  pipe_register #(.WORD_WIDTH(8), .DEPTH(2), .RESET_VALUE(8'hA5)) u_a (
    .clk(clk), .reset(a_reset), .clk_en(a_clk_en), .flush(a_flush),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data)
`ifdef PIPE_REGISTER_OCCUPANCY_EN
    , .occupancy(a_occ)
`endif
  );

  // DEPTH=1 instance
  logic       b_reset, b_s_valid, b_m_ready;
  logic       b_s_ready, b_m_valid;
  logic [7:0] b_s_data, b_m_data;
`ifdef PIPE_REGISTER_OCCUPANCY_EN
  logic       b_occ;
`endif

  pipe_register #(.WORD_WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) u_b (
    .clk(clk), .reset(b_reset), .clk_en(1'b1), .flush(1'b0),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data)
`ifdef PIPE_REGISTER_OCCUPANCY_EN
    , .occupancy(b_occ)
`endif
  );

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always @(negedge clk) begin
    if (a_reset) begin
      qa.delete();
    end else begin
      if (a_m_valid && a_m_ready) begin
        if (qa.size() == 0) chk("a_extra_out", 32'(a_m_data), 32'hx);
        else chk("a_sb_data", 32'(a_m_data), 32'(qa.pop_front()));
      end
      if (a_flush && a_clk_en) qa.delete();
      else if (a_s_valid && a_s_ready) qa.push_back(a_s_data);
    end
  end

  always @(negedge clk) begin
    if (b_reset) begin
      qb.delete();
    end else begin
      chk("b_mvalid", 32'(b_m_valid), 32'(qb.size() != 0));
      if (qb.size() == 1 && !b_m_ready)
        chk("b_sready_full", 32'(b_s_ready), 32'd0);
`ifdef PIPE_REGISTER_OCCUPANCY_EN
      chk("b_occ", 32'(b_occ), 32'(qb.size()));
`endif
      if (b_m_valid && b_m_ready) begin
        if (qb.size() == 0) chk("b_extra_out", 32'(b_m_data), 32'hx);
        else chk("b_sb_data", 32'(b_m_data), 32'(qb.pop_front()));
      end
      if (b_s_valid && b_s_ready) qb.push_back(b_s_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef PIPE_REGISTER_OCCUPANCY_EN
    chk(tag, 32'(a_occ), 32'(exp));
`endif
  endtask

  logic [6:0] mv_exp;

  initial begin
    a_reset = 1; a_clk_en = 1; a_flush = 0;
    a_s_valid = 0; a_m_ready = 0; a_s_data = 0;
    b_reset = 1; b_s_valid = 0; b_m_ready = 0; b_s_data = 0;
    tick();
    a_reset = 0; b_reset = 0;

    // reset / idle
    @(negedge clk);
    chk("rst_mvalid", 32'(a_m_valid), 32'd0);
    chk("rst_mdata", 32'(a_m_data), 32'hA5);
    chk("rst_sready", 32'(a_s_ready), 32'd1);
    chk_occ("rst_occ", 0);
    tick();

    // streaming latency and throughput
    mv_exp = 7'b0111100;
    a_m_ready = 1;
    for (int c = 0; c < 7; c++) begin
      a_s_valid = (c < 4);
      a_s_data  = 8'(c + 1);
      @(negedge clk);
      chk($sformatf("stream_mv%0d", c), 32'(a_m_valid), 32'(mv_exp[c]));
      tick();
    end
    a_s_valid = 0;

    // backpressure
    a_m_ready = 0;
    a_s_valid = 1; a_s_data = 8'd1;
    @(negedge clk);
    chk("bp_sready0", 32'(a_s_ready), 32'd1);
    tick();
    a_s_data = 8'd2;
    @(negedge clk);
    chk("bp_sready1", 32'(a_s_ready), 32'd1);
    tick();
    a_s_data = 8'd3;
    @(negedge clk);
    chk("bp_sready2", 32'(a_s_ready), 32'd0);
    chk("bp_mdata", 32'(a_m_data), 32'd1);
    chk_occ("bp_occ", 2);
    tick();
    a_m_ready = 1;
    @(negedge clk);
    chk("bp_full_pass", 32'(a_s_ready), 32'd1);
    chk_occ("bp_occ_full", 2);
    tick();
    a_s_valid = 0;
    repeat (4) tick();
    chk("bp_drain", 32'(qa.size()), 32'd0);

    // flush: stage0=7, stage1=8
    a_m_ready = 0;
    a_s_valid = 1; a_s_data = 8'd8;
    tick();
    a_s_data = 8'd7;
    tick();
    a_s_data = 8'd9; a_flush = 1;
    @(negedge clk);
    chk("fl_sready", 32'(a_s_ready), 32'd0);
    tick();
    a_flush = 0; a_s_valid = 0;
    @(negedge clk);
    chk("fl_mvalid", 32'(a_m_valid), 32'd0);
    chk("fl_mdata", 32'(a_m_data), 32'd8);
    chk("fl_sready_after", 32'(a_s_ready), 32'd1);
    chk_occ("fl_occ", 0);
    tick();

    // stall with clk_en=0, then reset while frozen
    a_s_valid = 1; a_s_data = 8'h31;
    tick();
    a_s_data = 8'h32;
    tick();
    a_clk_en = 0; a_m_ready = 1; a_s_data = 8'h44;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("st_sready%0d", c), 32'(a_s_ready), 32'd0);
      chk($sformatf("st_mvalid%0d", c), 32'(a_m_valid), 32'd0);
      tick();
    end
    a_clk_en = 1; a_m_ready = 0; a_s_valid = 0;
    @(negedge clk);
    chk("st_frozen_mv", 32'(a_m_valid), 32'd1);
    chk("st_frozen_md", 32'(a_m_data), 32'h31);
    chk_occ("st_frozen_occ", 2);
    tick();
    a_clk_en = 0; a_reset = 1;
    tick();
    a_clk_en = 1; a_reset = 0;
    @(negedge clk);
    chk("st_rst_mvalid", 32'(a_m_valid), 32'd0);
    chk("st_rst_mdata", 32'(a_m_data), 32'hA5);
    chk("st_rst_sready", 32'(a_s_ready), 32'd1);
    chk_occ("st_rst_occ", 0);
    tick();

    // DEPTH=1 random traffic
    for (int c = 0; c < 1000; c++) begin
      b_s_valid = 1'($urandom_range(0, 1));
      b_m_ready = 1'($urandom_range(0, 1));
      b_s_data  = 8'($urandom);
      tick();
    end
    b_s_valid = 0; b_m_ready = 1;
    repeat (3) tick();
    chk("b_drain", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
Parametrised multi-stage pipeline register with valid/ready flow control. It succeeds the single-word clock-enabled register: same reset and clock-enable semantics, but with DEPTH stages, per-stage valid tracking, backpressure, and flush. It is used wherever the datapath needs retiming stages that stall and drain without losing or duplicating words.

Parameters:
- WORD_WIDTH, 32, width of data word in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VALUE, 0, value loaded into every stage data register on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clock clk.
- clk_en  input  1  global enable; 0 freezes all state.
- flush  input  1  synchronous clear of all stage valid bits.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  pipe accepts s_data this cycle.
- s_data  input  WORD_WIDTH  upstream word.
- m_valid  output  1  m_data valid for downstream.
- m_ready  input  1  downstream accepts m_data.
- m_data  output  WORD_WIDTH  word in last stage.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages. Present only with PIPE_REGISTER_OCCUPANCY_EN.

Behaviour:
- State per stage k (0 = input side, DEPTH-1 = output side):
  - valid[k], cleared on reset.
  - data[k], loaded with RESET_VALUE on reset.
- Reset has highest priority. It applies even when clk_en=0.
- Next-cycle state after reset: all valid=0, all data=RESET_VALUE, m_valid=0, m_data=RESET_VALUE, occupancy=0.
- Output transfer: out_fire = m_valid && m_ready.
- Stage advance is computed from the output side backwards:
  - adv[DEPTH-1] = valid[DEPTH-1] && m_ready.
  - adv[k] = valid[k] && (!valid[k+1] || adv[k+1]).
  - Stage k+1 loads data[k] when stage k moves forward into it.
- s_ready = clk_en && !flush && (!valid[0] || adv[0]).
  - s_ready is combinational from m_ready through the chain. There is no skid buffer.
- Input transfer: in_fire = s_valid && s_ready. It loads data[0] <= s_data and sets valid[0].
- Bubbles collapse: a valid word moves into an empty downstream stage even when m_ready=0.
- Throughput is 1 word/cycle when m_ready is held high.
- Latency:
  - An accepted word appears on m_valid DEPTH cycles after acceptance when no stalls occur (DEPTH=2: accept at cycle 0, m_valid at cycle 2).
  - An empty pipe does not bypass.
- m_valid = valid[DEPTH-1] && clk_en, so no transfer is signalled while frozen.
- m_data = data[DEPTH-1] at all times. It holds its last value when invalid.
- A stage whose valid is 0 keeps its data. Data registers load only on a transfer into the stage.
- clk_en=0: no valid or data changes, s_ready=0, m_valid=0.
- flush=1 (with clk_en=1, reset=0):
  - All valid bits are cleared next cycle.
  - s_ready=0, so a simultaneous s_valid word is not accepted.
  - An out_fire in the flush cycle still completes; that word is considered consumed.
  - Data registers are unchanged.
- flush=1 with clk_en=0: ignored, because clk_en gates flush.
- Full pipe with m_ready=0: s_ready=0 and all state holds.
- Full pipe with m_ready=1: simultaneous in_fire and out_fire; occupancy is unchanged.
- Words are never dropped or duplicated except when discarded by flush or reset. Order is preserved.

Optional Feature:
- PIPE_REGISTER_OCCUPANCY_EN, defined:
  - Port occupancy exists and equals the count of set valid bits.
  - It is registered and updated in the same edge as valid[].
  - It reads 0 after reset or flush and DEPTH when full.
- PIPE_REGISTER_OCCUPANCY_EN, undefined: port and counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset and idle: WORD_WIDTH=8, DEPTH=2, RESET_VALUE=8'hA5, reset 1 cycle -> m_valid=0, m_data=8'hA5, s_ready=1, occupancy=0.
2. Streaming: m_ready=1, s_data=1,2,3,4 on consecutive cycles -> m_data 1,2,3,4 with m_valid starting 2 cycles after the first accept, 1 word/cycle, no gaps.
3. Backpressure: m_ready=0 while sending 1,2,3 -> 1 and 2 accepted, s_ready=0 on the third, occupancy=2. Then m_ready=1 -> out 1,2,3 in order, no loss or duplication.
4. Flush: pipe holds 7,8, flush=1 with s_valid=1 and s_data=9 -> next cycle m_valid=0, occupancy=0, 9 not accepted, m_data still 8.
5. Stall: clk_en=0 for 3 cycles with s_valid=1 and m_ready=1 -> s_ready=0, m_valid=0, state frozen. Then reset asserted while clk_en=0 -> state cleared next cycle.
6. DEPTH=1, random s_valid/m_ready over 1000 cycles -> scoreboard matches input order exactly, and s_ready is never asserted while the pipe is full and m_ready=0.
